// File: rtl/cpu_run_pkg.sv
// ----------------------------------------------------------------------------
// cpu_run_pkg
//
// Shared definitions for the CPU run controller:
//   run_state_t        - controller state encoding
//   DEF_*              - default values for the controller parameters
//   TIMER_W            - width of the WARMUP/DRAIN timer (covers 0..255)
// ----------------------------------------------------------------------------
package cpu_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } run_state_t;

    localparam int unsigned DEF_NUM_CORES     = 1;
    localparam int unsigned DEF_CNT_W         = 16;
    localparam int unsigned DEF_WARMUP_CYCLES = 1;
    localparam int unsigned DEF_DRAIN_CYCLES  = 4;

    localparam int unsigned TIMER_W = 8;

endpackage : cpu_run_pkg

// File: rtl/run_cnt.sv
// ----------------------------------------------------------------------------
// run_cnt
//
// Saturating, loadable down-counter used as the phase timer of the run
// controller (WARMUP length and DRAIN length share one instance because the
// two phases never overlap).
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (count -> 0)
//   load      in   load load_val on the next edge (has priority over dec)
//   load_val  in   W  value to load
//   dec       in   decrement by one on the next edge; holds at zero
//   count     out  W  current count
//   last      out  high while count == 1, i.e. the current cycle is the
//                  final cycle of the timed phase
// ----------------------------------------------------------------------------
module run_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         last
);

    // Load wins over decrement; decrement stops at zero instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign last = (count == W'(1));

endmodule : run_cnt

// File: rtl/cpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_run_ctrl
//
// Launches, supervises and terminates a run of up to NUM_CORES CPUs.
// A run goes IDLE/DONE -> WARMUP -> RUN -> (DRAIN) -> DONE. During RUN and
// DRAIN each enabled core is started until it reports halt; the run ends
// when every enabled core has halted (optionally followed by a DRAIN period)
// or when the cycle budget is used up.
//
// Parameters:
//   NUM_CORES      number of controlled CPUs (1..8)
//   CNT_W          width of cycle counter and budget
//   WARMUP_CYCLES  cycles start is held low after go (1..255)
//   DRAIN_CYCLES   cycles the run continues after the last halt (0..255)
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   go           in   launch request, honoured only in IDLE/DONE
//   core_en      in   NUM_CORES  enable mask, captured with go
//   max_cycles   in   CNT_W      RUN-cycle budget, captured with go, 0=unlimited
//   halt         in   NUM_CORES  per-core halt level from the CPUs
//   start        out  NUM_CORES  per-core run enable
//   busy         out  high in WARMUP, RUN, DRAIN
//   done         out  high in DONE
//   timeout      out  last run ended on budget exhaustion
//   halted       out  NUM_CORES  sticky halt record of current/last run
//   cycle_count  out  CNT_W      RUN+DRAIN cycles of current/last run
//
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int unsigned NUM_CORES     = DEF_NUM_CORES,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned WARMUP_CYCLES = DEF_WARMUP_CYCLES,
    parameter int unsigned DRAIN_CYCLES  = DEF_DRAIN_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic [NUM_CORES-1:0] core_en,
    input  logic [CNT_W-1:0]     max_cycles,
    input  logic [NUM_CORES-1:0] halt,
    output logic [NUM_CORES-1:0] start,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [NUM_CORES-1:0] halted,
    output logic [CNT_W-1:0]     cycle_count
);

    localparam logic [TIMER_W-1:0] WARMUP_LOAD = TIMER_W'(WARMUP_CYCLES);
    localparam logic [TIMER_W-1:0] DRAIN_LOAD  = TIMER_W'(DRAIN_CYCLES);
    localparam bit                 DRAIN_SKIP  = (DRAIN_CYCLES == 0);

    run_state_t state;

    logic [NUM_CORES-1:0] en_mask;
    logic [CNT_W-1:0]     budget;

    logic                 go_accept;
    logic [NUM_CORES-1:0] halted_next;
    logic [NUM_CORES-1:0] run_start;
    logic                 all_halted;
    logic                 budget_hit;
    logic [CNT_W-1:0]     count_inc;

    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_load_val;
    logic                 timer_dec;
    logic [TIMER_W-1:0]   timer_count;
    logic                 timer_last;

    // A launch needs at least one enabled core; otherwise go is dropped and
    // the controller stays where it is.
    assign go_accept = go && (core_en != '0) &&
                       ((state == ST_IDLE) || (state == ST_DONE));

    // Halts from disabled cores are masked so they never enter the record.
    // The halt seen this cycle already counts for the stop decision and for
    // dropping start on the following cycle.
    assign halted_next = halted | (halt & en_mask);
    assign run_start   = en_mask & ~halted_next;
    assign all_halted  = (halted_next == en_mask);

    // Budget compare is done one bit wider so the +1 cannot wrap; once the
    // counter saturates the budget can no longer match.
    assign budget_hit = (budget != '0) &&
                        (({1'b0, cycle_count} + (CNT_W+1)'(1)) == {1'b0, budget});

    assign count_inc = (&cycle_count) ? cycle_count : (cycle_count + CNT_W'(1));

    // The phase timer is loaded with the warmup length on launch and with the
    // drain length on the RUN->DRAIN step, and counts down inside either phase.
    always_comb begin
        timer_load     = 1'b0;
        timer_load_val = '0;
        timer_dec      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (go_accept) begin
                    timer_load     = 1'b1;
                    timer_load_val = WARMUP_LOAD;
                end
            end
            ST_WARMUP: begin
                timer_dec = 1'b1;
            end
            ST_RUN: begin
                if (all_halted && !DRAIN_SKIP) begin
                    timer_load     = 1'b1;
                    timer_load_val = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                timer_dec = 1'b1;
            end
            default: begin
            end
        endcase
    end

    run_cnt #(
        .W (TIMER_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_load_val),
        .dec      (timer_dec),
        .count    (timer_count),
        .last     (timer_last)
    );

    // Main controller. In RUN an all-halted condition is checked before the
    // budget so a halt arriving on the last budgeted cycle still ends the run
    // normally (no timeout).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            en_mask     <= '0;
            budget      <= '0;
            start       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            halted      <= '0;
            cycle_count <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (go_accept) begin
                        state       <= ST_WARMUP;
                        en_mask     <= core_en;
                        budget      <= max_cycles;
                        halted      <= '0;
                        cycle_count <= '0;
                        timeout     <= 1'b0;
                        start       <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end

                ST_WARMUP: begin
                    if (timer_last) begin
                        state <= ST_RUN;
                        start <= en_mask;
                    end
                end

                ST_RUN: begin
                    halted      <= halted_next;
                    cycle_count <= count_inc;
                    if (all_halted) begin
                        start <= '0;
                        if (DRAIN_SKIP) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else if (budget_hit) begin
                        state   <= ST_DONE;
                        start   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        start <= run_start;
                    end
                end

                ST_DRAIN: begin
                    halted      <= halted_next;
                    cycle_count <= count_inc;
                    if (timer_last) begin
                        state <= ST_DONE;
                        start <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        start <= run_start;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    start <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule : cpu_run_ctrl

// File: tb/tb_cpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cpu_run_ctrl
//
// Directed bench for cpu_run_ctrl. Four instances cover the parameter sets
// of interest:
//   dut_a  defaults (1 core, 16-bit count, warmup 1, drain 4)
//   dut_b  4 cores
//   dut_c  4-bit cycle counter
//   dut_d  2 cores, warmup 3, no drain, 8-bit counter
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
// ----------------------------------------------------------------------------
module tb_cpu_run_ctrl;

    logic clk;
    logic rst_n;

    int checkCount;
    int passCount;

    // dut_a signals
    logic        a_go;
    logic [0:0]  a_core_en;
    logic [15:0] a_max;
    logic [0:0]  a_halt;
    logic [0:0]  a_start;
    logic        a_busy;
    logic        a_done;
    logic        a_timeout;
    logic [0:0]  a_halted;
    logic [15:0] a_cc;

    // dut_b signals
    logic        b_go;
    logic [3:0]  b_core_en;
    logic [15:0] b_max;
    logic [3:0]  b_halt;
    logic [3:0]  b_start;
    logic        b_busy;
    logic        b_done;
    logic        b_timeout;
    logic [3:0]  b_halted;
    logic [15:0] b_cc;
    logic        b_start2Seen;

    // dut_c signals
    logic        c_go;
    logic [0:0]  c_core_en;
    logic [3:0]  c_max;
    logic [0:0]  c_halt;
    logic [0:0]  c_start;
    logic        c_busy;
    logic        c_done;
    logic        c_timeout;
    logic [0:0]  c_halted;
    logic [3:0]  c_cc;

    // dut_d signals
    logic        d_go;
    logic [1:0]  d_core_en;
    logic [7:0]  d_max;
    logic [1:0]  d_halt;
    logic [1:0]  d_start;
    logic        d_busy;
    logic        d_done;
    logic        d_timeout;
    logic [1:0]  d_halted;
    logic [7:0]  d_cc;

    cpu_run_ctrl dut_a (
        .clk (clk), .rst_n (rst_n), .go (a_go), .core_en (a_core_en),
        .max_cycles (a_max), .halt (a_halt), .start (a_start), .busy (a_busy),
        .done (a_done), .timeout (a_timeout), .halted (a_halted),
        .cycle_count (a_cc)
    );

    cpu_run_ctrl #(.NUM_CORES(4)) dut_b (
        .clk (clk), .rst_n (rst_n), .go (b_go), .core_en (b_core_en),
        .max_cycles (b_max), .halt (b_halt), .start (b_start), .busy (b_busy),
        .done (b_done), .timeout (b_timeout), .halted (b_halted),
        .cycle_count (b_cc)
    );

    cpu_run_ctrl #(.CNT_W(4)) dut_c (
        .clk (clk), .rst_n (rst_n), .go (c_go), .core_en (c_core_en),
        .max_cycles (c_max), .halt (c_halt), .start (c_start), .busy (c_busy),
        .done (c_done), .timeout (c_timeout), .halted (c_halted),
        .cycle_count (c_cc)
    );

    cpu_run_ctrl #(.NUM_CORES(2), .CNT_W(8), .WARMUP_CYCLES(3),
                   .DRAIN_CYCLES(0)) dut_d (
        .clk (clk), .rst_n (rst_n), .go (d_go), .core_en (d_core_en),
        .max_cycles (d_max), .halt (d_halt), .start (d_start), .busy (d_busy),
        .done (d_done), .timeout (d_timeout), .halted (d_halted),
        .cycle_count (d_cc)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records any cycle where the disabled core 2 of dut_b is started
    always @(negedge clk) begin
        if (b_start[2]) b_start2Seen = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic go, input logic [0:0] core_en,
                                 input logic [15:0] max_cycles, input logic [0:0] halt);
        a_go      = go;
        a_core_en = core_en;
        a_max     = max_cycles;
        a_halt    = halt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        checkCount   = 0;
        passCount    = 0;
        b_start2Seen = 1'b0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'd0, 1'b0);
        b_go = 1'b0; b_core_en = '0; b_max = '0; b_halt = '0;
        c_go = 1'b0; c_core_en = '0; c_max = '0; c_halt = '0;
        d_go = 1'b0; d_core_en = '0; d_max = '0; d_halt = '0;
        #12;
        rst_n = 1'b1;
        tick();

        $display("[TB] reset state");
        checkOutput("rst_busy",    32'(a_busy),    0);
        checkOutput("rst_done",    32'(a_done),    0);
        checkOutput("rst_start",   32'(a_start),   0);
        checkOutput("rst_cc",      32'(a_cc),      0);
        checkOutput("rst_halted",  32'(a_halted),  0);
        checkOutput("rst_timeout", 32'(a_timeout), 0);

        $display("[TB] single core, halt on RUN cycle 100");
        applyStimulus(1'b1, 1'b1, 16'd0, 1'b0);
        tick();
        checkOutput("a1_busy_warm",  32'(a_busy),  1);
        checkOutput("a1_start_warm", 32'(a_start), 0);
        applyStimulus(1'b0, 1'b1, 16'd0, 1'b0);
        tick();
        checkOutput("a1_start_run", 32'(a_start), 1);
        checkOutput("a1_cc_run0",   32'(a_cc),    0);
        ticks(99);
        checkOutput("a1_cc_99",     32'(a_cc),    99);
        checkOutput("a1_start_99",  32'(a_start), 1);
        applyStimulus(1'b0, 1'b1, 16'd0, 1'b1);
        tick();
        checkOutput("a1_start_drop", 32'(a_start), 0);
        checkOutput("a1_cc_100",     32'(a_cc),    100);
        checkOutput("a1_busy_drain", 32'(a_busy),  1);
        checkOutput("a1_done_drain", 32'(a_done),  0);
        ticks(3);
        checkOutput("a1_done_early", 32'(a_done),  0);
        checkOutput("a1_cc_103",     32'(a_cc),    103);
        tick();
        checkOutput("a1_done",    32'(a_done),    1);
        checkOutput("a1_busy",    32'(a_busy),    0);
        checkOutput("a1_cc_104",  32'(a_cc),      104);
        checkOutput("a1_timeout", 32'(a_timeout), 0);
        checkOutput("a1_halted",  32'(a_halted),  1);
        applyStimulus(1'b0, 1'b1, 16'd0, 1'b0);
        ticks(2);
        checkOutput("a1_done_hold", 32'(a_done), 1);
        checkOutput("a1_cc_hold",   32'(a_cc),   104);

        $display("[TB] go with empty mask is ignored");
        applyStimulus(1'b1, 1'b0, 16'd0, 1'b0);
        tick();
        checkOutput("a0_done", 32'(a_done), 1);
        checkOutput("a0_busy", 32'(a_busy), 0);
        checkOutput("a0_cc",   32'(a_cc),   104);

        $display("[TB] budget 50, no halt");
        applyStimulus(1'b1, 1'b1, 16'd50, 1'b0);
        tick();
        checkOutput("a2_cc_clear", 32'(a_cc),   0);
        checkOutput("a2_done_clr", 32'(a_done), 0);
        checkOutput("a2_busy",     32'(a_busy), 1);
        applyStimulus(1'b0, 1'b1, 16'd50, 1'b0);
        tick();
        ticks(49);
        checkOutput("a2_cc_49",   32'(a_cc),   49);
        checkOutput("a2_done_49", 32'(a_done), 0);
        tick();
        checkOutput("a2_done",    32'(a_done),    1);
        checkOutput("a2_timeout", 32'(a_timeout), 1);
        checkOutput("a2_cc_50",   32'(a_cc),      50);
        checkOutput("a2_start",   32'(a_start),   0);
        checkOutput("a2_busy",    32'(a_busy),    0);

        $display("[TB] budget 50, halt on RUN cycle 50");
        applyStimulus(1'b1, 1'b1, 16'd50, 1'b0);
        tick();
        checkOutput("a3_timeout_clr", 32'(a_timeout), 0);
        applyStimulus(1'b0, 1'b1, 16'd50, 1'b0);
        tick();
        ticks(49);
        applyStimulus(1'b0, 1'b1, 16'd50, 1'b1);
        tick();
        checkOutput("a3_busy_drain", 32'(a_busy),    1);
        checkOutput("a3_done_drain", 32'(a_done),    0);
        checkOutput("a3_timeout",    32'(a_timeout), 0);
        checkOutput("a3_cc_50",      32'(a_cc),      50);
        ticks(4);
        checkOutput("a3_done",       32'(a_done),    1);
        checkOutput("a3_timeout_dn", 32'(a_timeout), 0);
        checkOutput("a3_cc_54",      32'(a_cc),      54);

        $display("[TB] reset in RUN cycle 20");
        applyStimulus(1'b1, 1'b1, 16'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 16'd0, 1'b0);
        tick();
        ticks(19);
        checkOutput("a4_cc_19", 32'(a_cc), 19);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("a4_rst_start",  32'(a_start),  0);
        checkOutput("a4_rst_busy",   32'(a_busy),   0);
        checkOutput("a4_rst_cc",     32'(a_cc),     0);
        checkOutput("a4_rst_halted", 32'(a_halted), 0);
        #1;
        rst_n = 1'b1;
        tick();
        checkOutput("a4_idle_busy", 32'(a_busy), 0);
        checkOutput("a4_idle_done", 32'(a_done), 0);
        applyStimulus(1'b1, 1'b1, 16'd0, 1'b0);
        tick();
        checkOutput("a4_re_busy", 32'(a_busy), 1);
        applyStimulus(1'b0, 1'b1, 16'd0, 1'b0);
        tick();
        checkOutput("a4_re_start", 32'(a_start), 1);
        ticks(5);
        checkOutput("a4_re_cc5", 32'(a_cc), 5);
        applyStimulus(1'b0, 1'b1, 16'd0, 1'b1);
        tick();
        ticks(4);
        checkOutput("a4_re_done", 32'(a_done), 1);
        checkOutput("a4_re_cc",   32'(a_cc),   10);
        applyStimulus(1'b0, 1'b1, 16'd0, 1'b0);

        $display("[TB] four cores, mask 1011");
        b_core_en = 4'b1011;
        b_halt    = 4'b0100;
        b_go      = 1'b1;
        tick();
        b_go = 1'b0;
        tick();
        checkOutput("b_start_run", 32'(b_start), 32'b1011);
        ticks(9);
        b_halt = 4'b0101;
        tick();
        checkOutput("b_start_10",  32'(b_start),  32'b1010);
        checkOutput("b_halted_10", 32'(b_halted), 32'b0001);
        checkOutput("b_cc_10",     32'(b_cc),     10);
        ticks(9);
        b_halt = 4'b0111;
        tick();
        checkOutput("b_start_20",  32'(b_start),  32'b1000);
        checkOutput("b_halted_20", 32'(b_halted), 32'b0011);
        checkOutput("b_busy_20",   32'(b_busy),   1);
        ticks(9);
        checkOutput("b_start_29", 32'(b_start), 32'b1000);
        b_halt = 4'b1111;
        tick();
        checkOutput("b_start_30",  32'(b_start),  0);
        checkOutput("b_halted_30", 32'(b_halted), 32'b1011);
        checkOutput("b_busy_30",   32'(b_busy),   1);
        checkOutput("b_done_30",   32'(b_done),   0);
        ticks(4);
        checkOutput("b_done",      32'(b_done),       1);
        checkOutput("b_halted",    32'(b_halted),     32'b1011);
        checkOutput("b_cc_34",     32'(b_cc),         34);
        checkOutput("b_timeout",   32'(b_timeout),    0);
        checkOutput("b_start2",    32'(b_start2Seen), 0);
        b_halt = 4'b0000;

        $display("[TB] 4-bit counter saturation");
        c_core_en = 1'b1;
        c_go      = 1'b1;
        tick();
        c_go = 1'b0;
        tick();
        ticks(20);
        checkOutput("c_cc_sat",  32'(c_cc),   15);
        checkOutput("c_busy",    32'(c_busy), 1);
        c_go = 1'b1;
        tick();
        c_go = 1'b0;
        tick();
        checkOutput("c_go_cc",    32'(c_cc),    15);
        checkOutput("c_go_start", 32'(c_start), 1);
        checkOutput("c_go_done",  32'(c_done),  0);
        c_halt = 1'b1;
        tick();
        checkOutput("c_drain_busy", 32'(c_busy), 1);
        ticks(4);
        checkOutput("c_done",    32'(c_done),    1);
        checkOutput("c_cc_done", 32'(c_cc),      15);
        checkOutput("c_timeout", 32'(c_timeout), 0);
        c_halt = 1'b0;

        $display("[TB] warmup 3, no drain");
        d_core_en = 2'b11;
        d_max     = 8'd0;
        d_go      = 1'b1;
        tick();
        checkOutput("d_busy_w", 32'(d_busy),  1);
        checkOutput("d_start_w0", 32'(d_start), 0);
        tick();
        d_go = 1'b0;
        checkOutput("d_start_w1", 32'(d_start), 0);
        tick();
        checkOutput("d_start_w2", 32'(d_start), 0);
        tick();
        checkOutput("d_start_run", 32'(d_start), 32'b11);
        ticks(4);
        checkOutput("d_cc_4", 32'(d_cc), 4);
        d_halt = 2'b11;
        tick();
        checkOutput("d_done",    32'(d_done),    1);
        checkOutput("d_busy",    32'(d_busy),    0);
        checkOutput("d_cc_5",    32'(d_cc),      5);
        checkOutput("d_halted",  32'(d_halted),  32'b11);
        checkOutput("d_start",   32'(d_start),   0);
        d_halt = 2'b00;

        $display("[TB] halt and budget on the same cycle");
        d_max = 8'd3;
        d_go  = 1'b1;
        tick();
        d_go = 1'b0;
        ticks(3);
        ticks(2);
        checkOutput("d2_cc_2", 32'(d_cc), 2);
        d_halt = 2'b11;
        tick();
        checkOutput("d2_done",    32'(d_done),    1);
        checkOutput("d2_timeout", 32'(d_timeout), 0);
        checkOutput("d2_cc_3",    32'(d_cc),      3);
        d_halt = 2'b00;

        $display("[TB] budget of one cycle");
        d_max = 8'd1;
        d_go  = 1'b1;
        tick();
        d_go = 1'b0;
        ticks(3);
        checkOutput("d3_cc_0",   32'(d_cc),   0);
        checkOutput("d3_done_0", 32'(d_done), 0);
        tick();
        checkOutput("d3_done",    32'(d_done),    1);
        checkOutput("d3_timeout", 32'(d_timeout), 1);
        checkOutput("d3_cc_1",    32'(d_cc),      1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_cpu_run_ctrl
